// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: sticky owner with a burst cap, read responses routed back by port tag.
// Latency: grant is combinational (0 cycles); read data valid READ_LATENCY cycles after a read grant.
// Backpressure: a requester holds req and fields until its gnt; responses cannot be stalled.
module mem_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_func3,
    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_func3,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_ra,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rd
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

    logic                    owner;
    logic [CW-1:0]           burst_cnt;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_port;
    logic                    gnt_any;
    logic                    gnt_wen;

    // The owner keeps the memory under contention until it has used up its burst.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                if ((burst_cnt < BMAX) == (owner == 1'b0)) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    assign gnt_any = m0_gnt | m1_gnt;

    always_comb begin
        mem_wa    = '0;
        mem_ra    = '0;
        mem_wd    = '0;
        mem_func3 = '0;
        gnt_wen   = 1'b0;
        if (m0_gnt) begin
            mem_wa    = m0_addr;
            mem_ra    = m0_addr;
            mem_wd    = m0_wdata;
            mem_func3 = m0_func3;
            gnt_wen   = m0_wen;
        end else if (m1_gnt) begin
            mem_wa    = m1_addr;
            mem_ra    = m1_addr;
            mem_wd    = m1_wdata;
            mem_func3 = m1_func3;
            gnt_wen   = m1_wen;
        end
    end

    assign mem_wen = gnt_any & gnt_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else if (gnt_any) begin
            if (m1_gnt == owner) begin
                if (burst_cnt < BMAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                owner     <= m1_gnt;
                burst_cnt <= CW'(1);
            end
        end else begin
            burst_cnt <= '0;
        end
    end

    // Each stage carries {valid, port} so back-to-back reads keep their own tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
        end else begin
            pipe_vld[0]  <= gnt_any & ~gnt_wen;
            pipe_port[0] <= m1_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
        end
    end

    assign m0_rvalid = pipe_vld[READ_LATENCY-1] & ~pipe_port[READ_LATENCY-1];
    assign m1_rvalid = pipe_vld[READ_LATENCY-1] &  pipe_port[READ_LATENCY-1];
    assign m0_rdata  = mem_rd;
    assign m1_rdata  = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected grants and read responses,
// a negedge monitor pops and compares whenever the DUT shows a grant or an rvalid.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_func3, m1_func3;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_wen;
    logic [31:0] mem_wa, mem_ra, mem_wd;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rd = '0;

    typedef struct {
        logic        port;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
    } gnt_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(.MAX_BURST(4), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_func3(m0_func3),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_func3(m1_func3),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_ra(mem_ra), .mem_wd(mem_wd),
        .mem_func3(mem_func3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory contents seen by reads: one special word, everything else derived from the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if ((m0_gnt || m1_gnt) && !mem_wen) mem_rd <= mem_val(mem_ra);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m0_gnt && m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
        if (m0_rvalid && m1_rvalid) chk("dual_rvalid", 32'd1, 32'd0);
        if (m0_gnt || m1_gnt) begin
            if (gnt_q.size() == 0) begin
                chk("unexpected_gnt", {31'd0, m1_gnt}, 32'hFFFF_FFFF);
            end else begin
                gnt_t e;
                e = gnt_q.pop_front();
                chk("gnt_port", {31'd0, m1_gnt}, {31'd0, e.port});
                chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.wen});
                chk("mem_wa", mem_wa, e.addr);
                chk("mem_ra", mem_ra, e.addr);
                chk("mem_wd", mem_wd, e.wdata);
                chk("mem_func3", {29'd0, mem_func3}, {29'd0, e.func3});
                chk("burst_le_max", {31'd0, (dut.burst_cnt <= 4)}, 32'd1);
            end
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rvalid", {31'd0, m1_rvalid}, 32'hFFFF_FFFF);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rvalid_port", {31'd0, m1_rvalid}, {31'd0, r.port});
                chk("rdata", r.port ? m1_rdata : m0_rdata, r.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        gnt_t e;
        e.port = p; e.wen = w; e.addr = a; e.wdata = d; e.func3 = f;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic p, input logic [31:0] d);
        rsp_t r;
        r.port = p; r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic drv0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
        m0_req = r; m0_wen = w; m0_addr = a; m0_wdata = d; m0_func3 = f;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
        m1_req = r; m1_wen = w; m1_addr = a; m1_wdata = d; m1_func3 = f;
    endtask

    initial begin
        rst_n = 1'b0;
        drv0(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        drv1(1'b1, 1'b1, 32'h0000_0200, 32'h55, 3'b010);
        tick();
        tick();
        @(negedge clk);
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rst_mem_ra", mem_ra, 32'd0);

        // Release with both requesting: port 0 first, then the waiting write.
        tick();
        exp_gnt(1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        exp_rsp(1'b0, 32'hA5A5_0100);
        exp_gnt(1'b1, 1'b1, 32'h0000_0200, 32'h55, 3'b010);
        rst_n = 1'b1;
        tick();
        m0_req = 1'b0;
        tick();
        m1_req = 1'b0;
        tick();

        exp_gnt(1'b0, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        exp_rsp(1'b0, 32'hDEAD_BEEF);
        drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        tick();
        m0_req = 1'b0;
        tick();
        tick();

        // Continuous contention with burst cap 4.
        drv0(1'b1, 1'b1, 32'h0000_0400, 32'h1111_1111, 3'b000);
        drv1(1'b1, 1'b1, 32'h0000_0500, 32'h2222_2222, 3'b001);
        for (int i = 0; i < 9; i++) begin
            if ((i / 4) % 2 == 1) exp_gnt(1'b1, 1'b1, 32'h0000_0500, 32'h2222_2222, 3'b001);
            else                  exp_gnt(1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 3'b000);
        end
        repeat (9) tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // Three m0 grants, an idle cycle clears the burst, then four more m0 grants before m1.
        m0_req = 1'b1;
        repeat (3) exp_gnt(1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 3'b000);
        repeat (3) tick();
        m0_req = 1'b0;
        tick();
        repeat (4) exp_gnt(1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 3'b000);
        exp_gnt(1'b1, 1'b1, 32'h0000_0500, 32'h2222_2222, 3'b001);
        m0_req = 1'b1;
        m1_req = 1'b1;
        repeat (5) tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // Alternating reads, one port per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                exp_gnt(1'b0, 1'b0, 32'h0000_0020, 32'h0, 3'b010);
                exp_rsp(1'b0, 32'hA5A5_0020);
                drv0(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3'b010);
                m1_req = 1'b0;
            end else begin
                exp_gnt(1'b1, 1'b0, 32'h0000_0024, 32'h0, 3'b010);
                exp_rsp(1'b1, 32'hA5A5_0024);
                drv1(1'b1, 1'b0, 32'h0000_0024, 32'h0, 3'b010);
                m0_req = 1'b0;
            end
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        exp_gnt(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 3'b010);
        drv1(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 3'b010);
        tick();
        m1_req = 1'b0;
        tick();
        tick();

        // Read granted, then reset lands before its response; no rvalid may follow.
        exp_gnt(1'b0, 1'b0, 32'h0000_0030, 32'h0, 3'b010);
        drv0(1'b1, 1'b0, 32'h0000_0030, 32'h0, 3'b010);
        #6;
        rst_n = 1'b0;
        m0_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        end
        tick();

        chk("gnt_q_empty", gnt_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
